// File: rtl/mips_pkg.sv
// Shared types and helpers for the MIPS pipeline slice: FSM state encoding,
// default widths, the MEM/WB payload layout and the word-alignment test.
package mips_pkg;

  localparam int MIPS_DATA_W = 32;
  localparam int MIPS_REG_W  = 5;
  localparam int CNT_W       = 8;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic                   reg_write;
    logic                   memto_reg;
    logic [MIPS_DATA_W-1:0] alu_result;
    logic [MIPS_DATA_W-1:0] read_data;
    logic [MIPS_REG_W-1:0]  write_reg;
  } memwb_t;

  function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
    return (addr_lsb == 2'b00);
  endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. A bubble clears the writeback controls and the
// load data so the squashed instruction has no architectural effect.
module mem_wb_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bubble_i,
  input  logic              reg_write_i,
  input  logic              memto_reg_i,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic [DATA_W-1:0] read_data_i,
  input  logic [REG_W-1:0]  write_reg_i,
  output logic              reg_write_o,
  output logic              memto_reg_o,
  output logic [DATA_W-1:0] alu_result_o,
  output logic [DATA_W-1:0] read_data_o,
  output logic [REG_W-1:0]  write_reg_o
);

  logic              reg_write_q;
  logic              memto_reg_q;
  logic [DATA_W-1:0] alu_result_q;
  logic [DATA_W-1:0] read_data_q;
  logic [REG_W-1:0]  write_reg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_q  <= 1'b0;
      memto_reg_q  <= 1'b0;
      alu_result_q <= '0;
      read_data_q  <= '0;
      write_reg_q  <= '0;
    end else begin
      reg_write_q  <= reg_write_i & ~bubble_i;
      memto_reg_q  <= memto_reg_i & ~bubble_i;
      alu_result_q <= alu_result_i;
      read_data_q  <= bubble_i ? '0 : read_data_i;
      write_reg_q  <= write_reg_i;
    end
  end

  assign reg_write_o  = reg_write_q;
  assign memto_reg_o  = memto_reg_q;
  assign alu_result_o = alu_result_q;
  assign read_data_o  = read_data_q;
  assign write_reg_o  = write_reg_q;

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: data-memory access over a req/ack handshake, upstream stall,
// alignment and wait-timeout faults, and the MEM/WB pipeline register.
module mem_access_stage
  import mips_pkg::*;
#(
  parameter int DATA_W   = MIPS_DATA_W,
  parameter int REG_W    = MIPS_REG_W,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RegWrite,
  input  logic              MemtoReg,
  input  logic              MemWrite,
  input  logic              MemRead,
  input  logic [DATA_W-1:0] ALUresult,
  input  logic [DATA_W-1:0] writedata,
  input  logic [REG_W-1:0]  writeReg,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic              mem_err,
  output logic              RegWriteoutput,
  output logic              MemtoRegoutput,
  output logic [DATA_W-1:0] ALUresultoutput,
  output logic [DATA_W-1:0] readdataoutput,
  output logic [REG_W-1:0]  writeRegoutput
);

  localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  logic              access;
  logic              aligned;
  logic              req_c;
  logic              stall_c;
  logic              bubble;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] rdata_sel;

  assign access  = MemRead | MemWrite;
  assign aligned = is_word_aligned(ALUresult[1:0]);
  // A store wins when both MemRead and MemWrite are set, so it returns no data.
  assign ld_data = MemWrite ? '0 : mem_rdata;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_c     = 1'b0;
    stall_c   = 1'b0;
    bubble    = 1'b0;
    err_d     = 1'b0;
    rdata_sel = '0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (!aligned) begin
            bubble = 1'b1;
            err_d  = 1'b1;
          end else begin
            req_c = 1'b1;
            if (mem_ack) begin
              rdata_sel = ld_data;
            end else begin
              stall_c = 1'b1;
              bubble  = 1'b1;
              state_d = WAIT;
              cnt_d   = CNT_W'(1);
            end
          end
        end
      end
      WAIT: begin
        req_c = 1'b1;
        if (mem_ack) begin
          rdata_sel = ld_data;
          state_d   = IDLE;
          cnt_d     = '0;
        end else if (cnt_q < MAX_WAIT_C) begin
          stall_c = 1'b1;
          bubble  = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
        end else begin
          // Timeout: drop the request and release upstream in the same cycle.
          req_c   = 1'b0;
          bubble  = 1'b1;
          err_d   = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Gating with rst_n makes req/stall fall the instant reset asserts,
  // even while EX/MEM still presents an access.
  assign mem_req   = rst_n & req_c;
  assign stall     = rst_n & stall_c;
  assign mem_we    = MemWrite;
  assign mem_addr  = ALUresult;
  assign mem_wdata = writedata;
  assign mem_err   = err_q;

  mem_wb_reg #(
    .DATA_W (DATA_W),
    .REG_W  (REG_W)
  ) u_mem_wb_reg (
    .clk          (clk),
    .rst_n        (rst_n),
    .bubble_i     (bubble),
    .reg_write_i  (RegWrite),
    .memto_reg_i  (MemtoReg),
    .alu_result_i (ALUresult),
    .read_data_i  (rdata_sel),
    .write_reg_i  (writeReg),
    .reg_write_o  (RegWriteoutput),
    .memto_reg_o  (MemtoRegoutput),
    .alu_result_o (ALUresultoutput),
    .read_data_o  (readdataoutput),
    .write_reg_o  (writeRegoutput)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: an instruction-level model queues
// the expected per-cycle response; a monitor pops and compares it.
module tb_mem_access_stage;
  import mips_pkg::*;

  localparam int DW   = 32;
  localparam int RW   = 5;
  localparam int MAXW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          RegWrite, MemtoReg, MemWrite, MemRead;
  logic [DW-1:0] ALUresult, writedata;
  logic [RW-1:0] writeReg;
  logic          mem_req, mem_we;
  logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
  logic          mem_ack, stall, mem_err;
  logic          RegWriteoutput, MemtoRegoutput;
  logic [DW-1:0] ALUresultoutput, readdataoutput;
  logic [RW-1:0] writeRegoutput;

  always #5 clk = ~clk;

  mem_access_stage #(.DATA_W(DW), .REG_W(RW), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst_n(rst_n),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg), .MemWrite(MemWrite), .MemRead(MemRead),
    .ALUresult(ALUresult), .writedata(writedata), .writeReg(writeReg),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall), .mem_err(mem_err),
    .RegWriteoutput(RegWriteoutput), .MemtoRegoutput(MemtoRegoutput),
    .ALUresultoutput(ALUresultoutput), .readdataoutput(readdataoutput),
    .writeRegoutput(writeRegoutput)
  );

  typedef struct {
    logic          stall;
    logic          req;
    logic          we;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
    memwb_t        wb;
    logic          err;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: combinational response mid-cycle, registered response after the edge.
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        chk("stall", stall, mon_e.stall);
        chk("mem_req", mem_req, mon_e.req);
        if (mon_e.req) begin
          chk("mem_we", mem_we, mon_e.we);
          chk("mem_addr", mem_addr, mon_e.addr);
          chk("mem_wdata", mem_wdata, mon_e.wdata);
        end
        @(posedge clk);
        #1;
        chk("RegWriteoutput", RegWriteoutput, mon_e.wb.reg_write);
        chk("MemtoRegoutput", MemtoRegoutput, mon_e.wb.memto_reg);
        chk("ALUresultoutput", ALUresultoutput, mon_e.wb.alu_result);
        chk("readdataoutput", readdataoutput, mon_e.wb.read_data);
        chk("writeRegoutput", writeRegoutput, mon_e.wb.write_reg);
        chk("mem_err", mem_err, mon_e.err);
      end
    end
  end

  // One instruction at the EX/MEM boundary; k is the cycle index of the ack
  // (0 = same cycle as the request), negative or > MAXW means no ack.
  task automatic do_instr(input logic rw, input logic mtr, input logic mw, input logic mr,
                          input logic [DW-1:0] addr, input logic [DW-1:0] wd,
                          input logic [RW-1:0] wr, input int k, input logic [DW-1:0] rdv);
    exp_t   e;
    memwb_t pass, bub;
    int     ncyc;
    logic   acc;
    acc = mr | mw;
    RegWrite = rw; MemtoReg = mtr; MemWrite = mw; MemRead = mr;
    ALUresult = addr; writedata = wd; writeReg = wr;
    pass.reg_write = rw; pass.memto_reg = mtr; pass.alu_result = addr;
    pass.read_data = '0; pass.write_reg = wr;
    bub = pass;
    bub.reg_write = 1'b0; bub.memto_reg = 1'b0;
    e.we = mw; e.addr = addr; e.wdata = wd;
    if (!acc || (addr % 4) != 0) begin
      mem_ack   = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      e.stall = 1'b0; e.req = 1'b0;
      e.wb    = acc ? bub : pass;
      e.err   = acc;
      q.push_back(e);
      @(posedge clk); #1;
    end else begin
      ncyc = (k < 0 || k > MAXW) ? MAXW + 1 : k + 1;
      for (int i = 0; i < ncyc; i++) begin
        mem_ack   = (i == k);
        mem_rdata = (rdv != 0) ? rdv : $urandom;
        e.req = 1'b1;
        if (i == k) begin
          e.stall = 1'b0; e.wb = pass; e.err = 1'b0;
          e.wb.read_data = mw ? '0 : mem_rdata;
        end else if (i < MAXW) begin
          e.stall = 1'b1; e.wb = bub; e.err = 1'b0;
        end else begin
          e.stall = 1'b0; e.req = 1'b0; e.wb = bub; e.err = 1'b1;
        end
        q.push_back(e);
        @(posedge clk); #1;
      end
    end
    mem_ack = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_mem_err"}, mem_err, 0);
    chk({tag, "_RegWriteoutput"}, RegWriteoutput, 0);
    chk({tag, "_MemtoRegoutput"}, MemtoRegoutput, 0);
    chk({tag, "_ALUresultoutput"}, ALUresultoutput, 0);
    chk({tag, "_readdataoutput"}, readdataoutput, 0);
    chk({tag, "_writeRegoutput"}, writeRegoutput, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   n;
    logic mr, mw;
    logic [DW-1:0] a;
    rst_n = 1'b0;
    RegWrite = 0; MemtoReg = 0; MemWrite = 0; MemRead = 0;
    ALUresult = '0; writedata = '0; writeReg = '0; mem_rdata = '0; mem_ack = 1'b0;
    #1;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    do_instr(1, 0, 0, 0, 32'h1234, 32'h0, 5'd7, 0, 0);
    do_instr(1, 1, 0, 1, 32'h40, 32'h0, 5'd3, 0, 32'hDEADBEEF);
    do_instr(0, 0, 1, 0, 32'h80, 32'hA5A5, 5'd2, 3, 0);
    do_instr(1, 1, 0, 1, 32'h10, 32'h0, 5'd4, -1, 0);
    do_instr(1, 1, 0, 1, 32'h42, 32'h0, 5'd5, 0, 0);
    do_instr(1, 0, 0, 0, 32'h88, 32'h0, 5'd6, 0, 0);
    do_instr(1, 1, 1, 1, 32'h100, 32'h55AA, 5'd8, 1, 32'h12345678);
    do_instr(1, 1, 0, 1, 32'h20, 32'h0, 5'd9, MAXW, 0);

    // Reset during the second WAIT cycle of a load that never gets acked.
    RegWrite = 1; MemtoReg = 1; MemWrite = 0; MemRead = 1;
    ALUresult = 32'h10; writedata = '0; writeReg = 5'd11; mem_ack = 1'b0;
    e.req = 1'b1; e.we = 1'b0; e.addr = 32'h10; e.wdata = '0; e.err = 1'b0; e.stall = 1'b1;
    e.wb.reg_write = 0; e.wb.memto_reg = 0; e.wb.alu_result = 32'h10;
    e.wb.read_data = '0; e.wb.write_reg = 5'd11;
    for (int i = 0; i < 2; i++) begin
      q.push_back(e);
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1 chk_all_zero("rst_async");
    mem_ack = 1'b1;
    @(posedge clk); #1;
    chk_all_zero("rst_held");
    MemRead = 0; RegWrite = 0; MemtoReg = 0;
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("post_rst_ack_mem_req", mem_req, 0);
    chk("post_rst_ack_stall", stall, 0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    do_instr(1, 0, 0, 0, 32'h44, 32'h0, 5'd1, 0, 0);
    do_instr(1, 1, 0, 1, 32'h30, 32'h0, 5'd12, 2, 32'hCAFEF00D);

    for (int it = 0; it < 300; it++) begin
      n  = $urandom_range(0, 3);
      mr = (n == 1) || (n == 3);
      mw = (n == 2) || (n == 3);
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      do_instr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), mw, mr, a, $urandom,
               5'($urandom), ($urandom_range(0, 5) == 0) ? -1 : $urandom_range(0, MAXW + 2), 0);
    end

    RegWrite = 0; MemtoReg = 0; MemWrite = 0; MemRead = 0;
    n = 0;
    while (q.size() > 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    if (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d entries left, required 0", q.size());
    end
    repeat (2) @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Consumer of the EX/MEM pipeline register outputs; performs the MEM-stage data-memory access over a req/ack handshake.
- Holds the MEM/WB pipeline register and drives a stall back to IF/ID/EX while an access is outstanding.
- Enforces word alignment and a wait-cycle timeout, and reports faults on a one-cycle error pulse.

Parameters:
- DATA_W, 32, width of ALU result, store data and load data.
- REG_W, 5, register-file index width.
- MAX_WAIT, 15, maximum number of WAIT-state cycles before the access is abandoned (range 1..255).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- RegWrite  in  1  control bit from EX/MEM.
- MemtoReg  in  1  control bit from EX/MEM.
- MemWrite  in  1  control bit from EX/MEM.
- MemRead  in  1  control bit from EX/MEM.
- ALUresult  in  DATA_W  effective address, or the result to write back.
- writedata  in  DATA_W  store data.
- writeReg  in  REG_W  destination register.
- mem_req  out  1  memory request, combinational.
- mem_we  out  1  1 = store, 0 = load.
- mem_addr  out  DATA_W  equals ALUresult.
- mem_wdata  out  DATA_W  equals writedata.
- mem_rdata  in  DATA_W  load data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion strobe.
- stall  out  1  freeze upstream stages and the EX/MEM register, combinational.
- mem_err  out  1  registered one-cycle fault pulse.
- RegWriteoutput  out  1  MEM/WB register.
- MemtoRegoutput  out  1  MEM/WB register.
- ALUresultoutput  out  DATA_W  MEM/WB register.
- readdataoutput  out  DATA_W  MEM/WB register.
- writeRegoutput  out  REG_W  MEM/WB register.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, wait counter=0. All MEM/WB outputs are 0 and mem_err=0. mem_req and stall fall immediately. An in-flight request is dropped; an ack arriving after reset is ignored.
- Definitions:
  - access = MemRead | MemWrite.
  - aligned = (ALUresult[1:0] == 2'b00).
  - mem_we = MemWrite; a store wins if both MemRead and MemWrite are set.
- IDLE, no access:
  - stall=0, mem_req=0.
  - On each clk, MEM/WB loads RegWrite, MemtoReg, ALUresult and writeReg; readdataoutput loads 0. Latency is 1 cycle.
- IDLE, access and not aligned:
  - No request; stall=0.
  - MEM/WB loads a bubble: RegWriteoutput=0, MemtoRegoutput=0, other fields as passed.
  - mem_err=1 on the next cycle only.
- IDLE, access and aligned: mem_req=1.
  - If mem_ack is high in the same cycle (zero-wait): stall=0, MEM/WB loads normally with readdataoutput=mem_rdata (loads) or 0 (stores). Stay in IDLE.
  - Otherwise: stall=1, MEM/WB loads a bubble, go to WAIT, counter=1.
- WAIT:
  - mem_req=1; mem_we, mem_addr and mem_wdata come from the held EX/MEM values, which upstream keeps stable because of stall.
  - !mem_ack and counter < MAX_WAIT: stall=1, bubble into MEM/WB, counter+1.
  - mem_ack: stall=0, MEM/WB loads the instruction (readdata as above), go to IDLE, counter=0.
  - !mem_ack and counter == MAX_WAIT: mem_req=0 and stall=0 this cycle, bubble into MEM/WB (instruction squashed), mem_err pulse next cycle, go to IDLE.
- mem_ack seen while mem_req=0 is ignored.
- MAX_WAIT=1 permits exactly one WAIT cycle.
- A store never sets RegWriteoutput beyond the value passed from EX/MEM; the block does not alter RegWrite except for bubbles.
- stall depends combinationally on mem_ack and on the EX/MEM inputs. Upstream must register it, not loop it back combinationally into these inputs.

Decomposition:
- Shared package mips_pkg:
  - state enum {IDLE, WAIT};
  - DATA_W and REG_W defaults;
  - a struct for the MEM/WB payload (RegWrite, MemtoReg, ALUresult, readdata, writeReg);
  - a function is_word_aligned.
- One natural sub-module, mem_wb_reg: the MEM/WB register with a bubble input and asynchronous active-low reset.
- The FSM, counter and handshake stay in mem_access_stage.

Test Plan:
- ALU op: RegWrite=1, MemRead=MemWrite=0, ALUresult=0x1234, writeReg=7 -> next cycle RegWriteoutput=1, ALUresultoutput=0x1234, writeRegoutput=7, stall never asserted.
- Zero-wait load: MemRead=1, ALUresult=0x40, mem_ack the same cycle, mem_rdata=0xDEADBEEF -> stall=0, next cycle readdataoutput=0xDEADBEEF, MemtoRegoutput=1.
- 3-wait store: MemWrite=1, addr=0x80, writedata=0xA5A5, ack on the 4th cycle -> stall high for 3 cycles, mem_wdata=0xA5A5 stable throughout, 3 bubbles with RegWriteoutput=0, then completion.
- Timeout: MemRead=1, addr=0x10, MAX_WAIT=4, no ack -> stall high for 4 cycles, then mem_req=0 and stall=0 together, mem_err pulses 1 cycle, RegWriteoutput=0.
- Misaligned: MemRead=1, ALUresult=0x42 -> mem_req never asserted, mem_err pulse next cycle, bubble in MEM/WB.
- Reset mid-WAIT: assert rst_n=0 during cycle 2 of WAIT -> mem_req, stall and all outputs go 0 immediately; a later ack has no effect; the next access after reset proceeds normally.
